// File: rtl/rocketcpu_sample_fifo.sv
// Wishbone-attached stereo sample FIFO: the CPU pushes words, the audio side pops one per strobe,
// and a level-threshold IRQ asks firmware for a refill.
module rocketcpu_sample_fifo #(
    parameter int DEPTH_LOG2 = 5,
    parameter int WIDTH      = 32
) (
    input  logic             i_wb_clk,
    input  logic             i_rst_n,
    input  logic [31:0]      i_wb_adr,
    input  logic [31:0]      i_wb_dat,
    input  logic [3:0]       i_wb_sel,
    input  logic             i_wb_we,
    input  logic             i_wb_cyc,
    output logic [31:0]      o_wb_rdt,
    output logic             o_wb_ack,
    input  logic             i_sample_strobe,
    output logic [WIDTH-1:0] o_sample,
    output logic             o_sample_valid,
    output logic             o_irq
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 2;
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [LW-1:0]         level_t;
    typedef enum logic [1:0] {REG_DATA, REG_STATUS, REG_THRESH, REG_CTRL} reg_t;
    typedef enum logic {S_IDLE, S_ACK} bus_state_t;

    // Reset asserts immediately but releases only after two clean clock edges.
    logic [1:0] rst_sync;
    logic       rst_n;
    always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
        if (!i_rst_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    logic unused_adr;
    assign unused_adr = ^{i_wb_adr[31:4], i_wb_adr[1:0]};

    bus_state_t  state, state_next;
    reg_t        acc_reg;
    logic        acc_we;
    logic [31:0] acc_dat;
    logic [3:0]  acc_sel;

    always_ff @(posedge i_wb_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            acc_reg <= REG_DATA;
            acc_we  <= 1'b0;
            acc_dat <= '0;
            acc_sel <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && i_wb_cyc) begin
                acc_reg <= reg_t'(i_wb_adr[3:2]);
                acc_we  <= i_wb_we;
                acc_dat <= i_wb_dat;
                acc_sel <= i_wb_sel;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (i_wb_cyc) state_next = S_ACK;
            S_ACK:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    logic [WIDTH-1:0] mem [DEPTH];
    ptr_t   wptr, rptr;
    level_t level, level_next;
    logic   ovf, unf, enable, irq_en;
    level_t thresh;

    logic commit, push_req, push_ok, pop_req, pop_ok, flush, status_wr;
    logic ovf_set, unf_set, is_empty, is_full;
    logic enable_next, irq_en_next;
    level_t thresh_next;

    assign o_wb_ack = (state == S_ACK);
    assign commit   = o_wb_ack && acc_we;

    always_comb begin
        push_req    = commit && acc_reg == REG_DATA && acc_sel == 4'hF;
        flush       = commit && acc_reg == REG_CTRL && acc_dat[1];
        status_wr   = commit && acc_reg == REG_STATUS;
        is_empty    = (level == '0);
        is_full     = (level == LEVEL_FULL);
        pop_req     = i_sample_strobe && enable && !flush;
        pop_ok      = pop_req && !is_empty;
        unf_set     = pop_req && is_empty;
        push_ok     = push_req && (!is_full || pop_ok);
        ovf_set     = push_req && !push_ok;
        level_next  = flush ? '0 : level + level_t'(push_ok) - level_t'(pop_ok);
        enable_next = (commit && acc_reg == REG_CTRL) ? acc_dat[0] : enable;
        irq_en_next = (commit && acc_reg == REG_THRESH) ? acc_dat[31] : irq_en;
        thresh_next = (commit && acc_reg == REG_THRESH) ? acc_dat[LW-1:0] : thresh;
    end

    always_comb begin
        o_wb_rdt = '0;
        if (o_wb_ack) begin
            case (acc_reg)
                REG_STATUS: begin
                    o_wb_rdt        = 32'(level);
                    o_wb_rdt[11:8]  = {ovf, unf, is_full, is_empty};
                end
                REG_THRESH: begin
                    o_wb_rdt        = 32'(thresh);
                    o_wb_rdt[31]    = irq_en;
                end
                REG_CTRL:   o_wb_rdt[0] = enable;
                default:    o_wb_rdt = '0;
            endcase
        end
    end

    // NOTE: the sample storage has no reset so it can map onto block RAM; only pointers are reset.
    always_ff @(posedge i_wb_clk) begin
        if (push_ok) mem[wptr] <= acc_dat[WIDTH-1:0];
    end

    always_ff @(posedge i_wb_clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr           <= '0;
            rptr           <= '0;
            level          <= '0;
            ovf            <= 1'b0;
            unf            <= 1'b0;
            enable         <= 1'b0;
            irq_en         <= 1'b0;
            thresh         <= '0;
            o_sample       <= '0;
            o_sample_valid <= 1'b0;
            o_irq          <= 1'b0;
        end else begin
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (push_ok) wptr <= wptr + ptr_t'(1);
                if (pop_ok)  rptr <= rptr + ptr_t'(1);
            end
            level  <= level_next;
            enable <= enable_next;
            irq_en <= irq_en_next;
            thresh <= thresh_next;
            // A new event in the same cycle as its W1C clear keeps the flag set.
            ovf <= (ovf && !(status_wr && acc_dat[11])) || ovf_set;
            unf <= (unf && !(status_wr && acc_dat[10])) || unf_set;
            if (pop_ok)       o_sample <= mem[rptr];
            else if (unf_set) o_sample <= '0;
            o_sample_valid <= pop_ok;
            o_irq          <= irq_en_next && enable_next && (level_next <= thresh_next);
        end
    end
endmodule

// File: tb/tb_rocketcpu_sample_fifo.sv
// Self-checking bench for rocketcpu_sample_fifo: register table, directed corner sequences,
// then random traffic against a queue-based reference model.
module tb_rocketcpu_sample_fifo;
    localparam int DEPTH = 32;

    logic        i_wb_clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] i_wb_adr;
    logic [31:0] i_wb_dat;
    logic [3:0]  i_wb_sel;
    logic        i_wb_we;
    logic        i_wb_cyc;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;
    logic        i_sample_strobe;
    logic [31:0] o_sample;
    logic        o_sample_valid;
    logic        o_irq;

    always #5 i_wb_clk = ~i_wb_clk;

    rocketcpu_sample_fifo #(.DEPTH_LOG2(5), .WIDTH(32)) dut (
        .i_wb_clk(i_wb_clk), .i_rst_n(i_rst_n), .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat),
        .i_wb_sel(i_wb_sel), .i_wb_we(i_wb_we), .i_wb_cyc(i_wb_cyc), .o_wb_rdt(o_wb_rdt),
        .o_wb_ack(o_wb_ack), .i_sample_strobe(i_sample_strobe), .o_sample(o_sample),
        .o_sample_valid(o_sample_valid), .o_irq(o_irq)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: the FIFO is a queue, the registers are plain variables.
    logic [31:0] q[$];
    bit          m_ovf, m_unf, m_en, m_irq_en, m_valid, m_irq;
    int          m_thresh;
    logic [31:0] m_sample;

    bit          c_active;
    logic [1:0]  c_reg;
    logic        c_we;
    logic [31:0] c_dat;
    logic [3:0]  c_sel;

    task automatic model_reset();
        q.delete();
        m_ovf = 0; m_unf = 0; m_en = 0; m_irq_en = 0; m_valid = 0; m_irq = 0;
        m_thresh = 0; m_sample = '0; c_active = 0;
    endtask

    task automatic model_edge(input bit strobe);
        bit flush, pop_req, ovf_set, unf_set;
        flush   = c_active && c_we && c_reg == 2'd3 && c_dat[1];
        pop_req = strobe && m_en && !flush;
        ovf_set = 0;
        unf_set = 0;
        m_valid = 0;
        if (pop_req) begin
            if (q.size() > 0) begin
                m_sample = q.pop_front();
                m_valid  = 1;
            end else begin
                m_sample = '0;
                unf_set  = 1;
            end
        end
        if (c_active && c_we) begin
            case (c_reg)
                2'd0: if (c_sel == 4'hF) begin
                          if (q.size() < DEPTH) q.push_back(c_dat);
                          else ovf_set = 1;
                      end
                2'd1: begin
                          if (c_dat[11]) m_ovf = 0;
                          if (c_dat[10]) m_unf = 0;
                      end
                2'd2: begin
                          m_irq_en = c_dat[31];
                          m_thresh = int'(c_dat[6:0]);
                      end
                default: begin
                          m_en = c_dat[0];
                          if (c_dat[1]) q.delete();
                      end
            endcase
        end
        if (ovf_set) m_ovf = 1;
        if (unf_set) m_unf = 1;
        m_irq = m_irq_en && m_en && (q.size() <= m_thresh);
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] r);
        logic [31:0] v;
        v = '0;
        case (r)
            2'd1: begin
                v     = 32'(q.size());
                v[11] = m_ovf;
                v[10] = m_unf;
                v[9]  = (q.size() == DEPTH);
                v[8]  = (q.size() == 0);
            end
            2'd2: begin
                v     = 32'(m_thresh);
                v[31] = m_irq_en;
            end
            2'd3: v[0] = m_en;
            default: v = '0;
        endcase
        return v;
    endfunction

    // One clock: drive strobe at the falling edge, step the model, compare on the next falling edge.
    task automatic cycle(input bit strobe);
        i_sample_strobe = strobe;
        model_edge(strobe);
        @(posedge i_wb_clk);
        @(negedge i_wb_clk);
        i_sample_strobe = 1'b0;
        check("o_sample", o_sample, m_sample);
        check("o_sample_valid", 32'(o_sample_valid), 32'(m_valid));
        check("o_irq", 32'(o_irq), 32'(m_irq));
    endtask

    task automatic wb(input logic [1:0] r, input logic we, input logic [31:0] d,
                      input logic [3:0] s, input bit strobe, output logic [31:0] rd);
        i_wb_adr = 32'h0600_0000 | (32'(r) << 2);
        i_wb_dat = d;
        i_wb_sel = s;
        i_wb_we  = we;
        i_wb_cyc = 1'b1;
        cycle(1'b0);
        check("wb_ack", 32'(o_wb_ack), 32'd1);
        rd = o_wb_rdt;
        check("wb_rdt", rd, model_read(r));
        i_wb_cyc = 1'b0;
        c_active = 1; c_reg = r; c_we = we; c_dat = d; c_sel = s;
        cycle(strobe);
        c_active = 0;
        check("wb_ack_single", 32'(o_wb_ack), 32'd0);
    endtask

    typedef struct {
        logic [1:0]  r;
        logic        we;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[15];

    initial begin
        logic [31:0] rd;
        logic [31:0] marker;

        tbl[0]  = '{2'd1, 1'b0, 32'h0,          4'hF, 32'h0000_0100};
        tbl[1]  = '{2'd2, 1'b1, 32'h8000_0045,  4'hF, 32'h0};
        tbl[2]  = '{2'd2, 1'b0, 32'h0,          4'hF, 32'h8000_0045};
        tbl[3]  = '{2'd2, 1'b1, 32'hFFFF_FFFF,  4'hF, 32'h0};
        tbl[4]  = '{2'd2, 1'b0, 32'h0,          4'hF, 32'h8000_007F};
        tbl[5]  = '{2'd2, 1'b1, 32'h0,          4'hF, 32'h0};
        tbl[6]  = '{2'd2, 1'b0, 32'h0,          4'hF, 32'h0};
        tbl[7]  = '{2'd3, 1'b1, 32'hFFFF_FFFE,  4'hF, 32'h0};
        tbl[8]  = '{2'd3, 1'b0, 32'h0,          4'hF, 32'h0};
        tbl[9]  = '{2'd3, 1'b1, 32'h1,          4'hF, 32'h0};
        tbl[10] = '{2'd3, 1'b0, 32'h0,          4'hF, 32'h1};
        tbl[11] = '{2'd0, 1'b0, 32'h0,          4'hF, 32'h0};
        tbl[12] = '{2'd0, 1'b1, 32'h0000_DEAD,  4'h7, 32'h0};
        tbl[13] = '{2'd1, 1'b0, 32'h0,          4'hF, 32'h0000_0100};
        tbl[14] = '{2'd3, 1'b1, 32'h0,          4'hF, 32'h0};

        i_rst_n = 1'b0;
        i_wb_adr = '0; i_wb_dat = '0; i_wb_sel = '0; i_wb_we = 1'b0; i_wb_cyc = 1'b0;
        i_sample_strobe = 1'b0;
        model_reset();
        @(negedge i_wb_clk);
        @(negedge i_wb_clk);
        check("reset_ack", 32'(o_wb_ack), 32'd0);
        check("reset_sample", o_sample, 32'd0);
        check("reset_valid", 32'(o_sample_valid), 32'd0);
        check("reset_irq", 32'(o_irq), 32'd0);
        i_rst_n = 1'b1;
        repeat (3) cycle(1'b0);

        // Register table
        for (int i = 0; i < 15; i++) begin
            wb(tbl[i].r, tbl[i].we, tbl[i].d, tbl[i].s, 1'b0, rd);
            if (!tbl[i].we) check($sformatf("tbl[%0d]_rdt", i), rd, tbl[i].exp);
        end

        // Two pushes, then two pops in order
        wb(2'd0, 1'b1, 32'h1234_ABCD, 4'hF, 1'b0, rd);
        wb(2'd0, 1'b1, 32'h0001_0002, 4'hF, 1'b0, rd);
        wb(2'd1, 1'b0, 32'h0, 4'hF, 1'b0, rd);
        check("two_push_status", rd, 32'h0000_0002);
        wb(2'd3, 1'b1, 32'h1, 4'hF, 1'b0, rd);
        cycle(1'b1);
        check("pop1_sample", o_sample, 32'h1234_ABCD);
        check("pop1_valid", 32'(o_sample_valid), 32'd1);
        cycle(1'b0);
        check("pop1_valid_drop", 32'(o_sample_valid), 32'd0);
        cycle(1'b1);
        check("pop2_sample", o_sample, 32'h0001_0002);
        wb(2'd1, 1'b0, 32'h0, 4'hF, 1'b0, rd);
        check("two_pop_status", rd, 32'h0000_0100);

        // Overflow: 33 pushes with the audio side disabled
        wb(2'd3, 1'b1, 32'h0, 4'hF, 1'b0, rd);
        for (int i = 0; i < 33; i++) wb(2'd0, 1'b1, 32'h1000 + 32'(i), 4'hF, 1'b0, rd);
        wb(2'd1, 1'b0, 32'h0, 4'hF, 1'b0, rd);
        check("ovf_status", rd, 32'h0000_0A20);
        wb(2'd1, 1'b1, 32'h0000_0800, 4'hF, 1'b0, rd);
        wb(2'd1, 1'b0, 32'h0, 4'hF, 1'b0, rd);
        check("ovf_cleared", rd, 32'h0000_0220);

        // Full FIFO: push commits in the same cycle as a pop
        wb(2'd3, 1'b1, 32'h1, 4'hF, 1'b0, rd);
        marker = 32'hCAFE_F00D;
        wb(2'd0, 1'b1, marker, 4'hF, 1'b1, rd);
        check("full_pushpop_sample", o_sample, 32'h0000_1000);
        wb(2'd1, 1'b0, 32'h0, 4'hF, 1'b0, rd);
        check("full_pushpop_status", rd, 32'h0000_0220);
        for (int i = 0; i < 32; i++) cycle(1'b1);
        check("marker_last", o_sample, marker);

        // Underrun on empty FIFO, then the same strobe while disabled
        cycle(1'b1);
        check("unf_sample", o_sample, 32'd0);
        check("unf_valid", 32'(o_sample_valid), 32'd0);
        wb(2'd1, 1'b0, 32'h0, 4'hF, 1'b0, rd);
        check("unf_status", rd, 32'h0000_0500);
        wb(2'd1, 1'b1, 32'h0000_0400, 4'hF, 1'b0, rd);
        wb(2'd3, 1'b1, 32'h0, 4'hF, 1'b0, rd);
        cycle(1'b1);
        wb(2'd1, 1'b0, 32'h0, 4'hF, 1'b0, rd);
        check("disabled_no_unf", rd, 32'h0000_0100);

        // Threshold IRQ, flush keeping the IRQ, then IRQ disable
        wb(2'd2, 1'b1, 32'h8000_0004, 4'hF, 1'b0, rd);
        wb(2'd3, 1'b1, 32'h1, 4'hF, 1'b0, rd);
        for (int i = 0; i < 6; i++) wb(2'd0, 1'b1, 32'hA000 + 32'(i), 4'hF, 1'b0, rd);
        check("irq_level6", 32'(o_irq), 32'd0);
        cycle(1'b1);
        check("irq_level5", 32'(o_irq), 32'd0);
        cycle(1'b1);
        check("irq_level4", 32'(o_irq), 32'd1);
        wb(2'd3, 1'b1, 32'h3, 4'hF, 1'b0, rd);
        check("irq_after_flush", 32'(o_irq), 32'd1);
        wb(2'd1, 1'b0, 32'h0, 4'hF, 1'b0, rd);
        check("flush_status", rd, 32'h0000_0100);
        wb(2'd2, 1'b1, 32'h0, 4'hF, 1'b0, rd);
        check("irq_disabled", 32'(o_irq), 32'd0);

        // Reset asserted in the middle of a bus access with data in flight
        wb(2'd0, 1'b1, 32'h5555_AAAA, 4'hF, 1'b0, rd);
        cycle(1'b1);
        wb(2'd0, 1'b1, 32'h7777_8888, 4'hF, 1'b0, rd);
        i_wb_adr = 32'h0600_0004; i_wb_we = 1'b0; i_wb_cyc = 1'b1;
        @(posedge i_wb_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("midrst_ack", 32'(o_wb_ack), 32'd0);
        check("midrst_rdt", o_wb_rdt, 32'd0);
        check("midrst_sample", o_sample, 32'd0);
        check("midrst_valid", 32'(o_sample_valid), 32'd0);
        check("midrst_irq", 32'(o_irq), 32'd0);
        i_wb_cyc = 1'b0;
        model_reset();
        @(negedge i_wb_clk);
        i_rst_n = 1'b1;
        repeat (3) cycle(1'b0);
        wb(2'd1, 1'b0, 32'h0, 4'hF, 1'b0, rd);
        check("post_reset_status", rd, 32'h0000_0100);

        // Random traffic against the model
        for (int i = 0; i < 500; i++) begin
            int op;
            op = int'($urandom_range(0, 9));
            case (op)
                0, 1, 2, 3: wb(2'd0, 1'b1, $urandom,
                               ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF,
                               1'($urandom), rd);
                4, 5: cycle(1'($urandom));
                6: wb(2'd1, 1'b0, 32'h0, 4'hF, 1'($urandom), rd);
                7: wb(2'd1, 1'b1, $urandom, 4'hF, 1'($urandom), rd);
                8: wb(2'd2, 1'b1, {1'($urandom), 24'($urandom), 7'($urandom_range(0, 40))},
                      4'hF, 1'($urandom), rd);
                default: wb(2'd3, 1'b1,
                            {30'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0)},
                            4'hF, 1'($urandom), rd);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
